// File: rtl/lcd_hd44780_writer.sv
// lcd_hd44780_writer: HD44780 4-bit writer with built-in power-on init and cycle-count timing.
module lcd_hd44780_writer #(
    parameter int CNT_W       = 18,
    parameter int T_PWRUP     = 180000,
    parameter int T_INIT1     = 49200,
    parameter int T_INIT2     = 1200,
    parameter int T_SETUP     = 1,
    parameter int T_EPW       = 6,
    parameter int T_HOLD      = 12,
    parameter int T_EXEC      = 480,
    parameter int T_EXEC_LONG = 19680
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       init_done,
    output logic [3:0] lcd_dq,
    output logic       lcd_rs,
    output logic       lcd_e
);
    localparam logic [2:0] S_PWR   = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_EHIGH = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_IDLE  = 3'd5;

    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_PWRUP     = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] L_INIT1     = CNT_W'(T_INIT1 - 1);
    localparam logic [CNT_W-1:0] L_INIT2     = CNT_W'(T_INIT2 - 1);
    localparam logic [CNT_W-1:0] L_SETUP     = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] L_EPW       = CNT_W'(T_EPW - 1);
    localparam logic [CNT_W-1:0] L_HOLD      = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] L_EXEC      = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] L_EXEC_LONG = CNT_W'(T_EXEC_LONG - 1);

    localparam logic [7:0] INIT_ROM [4] = '{8'h28, 8'h0C, 8'h01, 8'h06};

    logic [2:0]       state;
    logic [2:0]       step;
    logic [2:0]       item_idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] ld_wait;
    logic [3:0]       lo_q;
    logic [7:0]       item_byte;
    logic [7:0]       ld_byte;
    logic             armed;
    logic             nib_only;
    logic             low_phase;
    logic             last;
    logic             start_user;
    logic             start_item;
    logic             ld_rs;
    logic             ld_nib_only;

    // Init items 0..3 are bare nibbles (3,3,3,2); items 4..7 are full ROM bytes.
    always_comb begin
        last        = cnt == '0;
        item_idx    = state == S_PWR ? 3'd0 : step + 3'd1;
        item_byte   = item_idx[2] ? INIT_ROM[item_idx[1:0]] : {item_idx == 3'd3 ? 4'h2 : 4'h3, 4'h0};
        start_user  = state == S_IDLE && in_valid && in_ready;
        start_item  = start_user || (last && ((state == S_PWR && armed) ||
                      (state == S_WAIT && !init_done && step != 3'd7)));
        ld_byte     = start_user ? in_data : item_byte;
        ld_rs       = start_user && in_rs;
        ld_nib_only = !start_user && !item_idx[2];
        ld_wait     = ld_nib_only ? (item_idx == 3'd0 ? L_INIT1 : L_INIT2) :
                      (!ld_rs && ld_byte[7:2] == 6'd0) ? L_EXEC_LONG : L_EXEC;
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            state     <= S_PWR;
            cnt       <= '0;
            armed     <= 1'b0;
            step      <= 3'd0;
            lo_q      <= 4'h0;
            wait_q    <= '0;
            nib_only  <= 1'b0;
            low_phase <= 1'b0;
            in_ready  <= 1'b0;
            init_done <= 1'b0;
            lcd_dq    <= 4'h0;
            lcd_rs    <= 1'b0;
            lcd_e     <= 1'b0;
        end else begin
            if (!last)
                cnt <= cnt - ONE;
            if (start_item) begin
                lo_q      <= ld_byte[3:0];
                wait_q    <= ld_wait;
                nib_only  <= ld_nib_only;
                low_phase <= 1'b0;
                lcd_dq    <= ld_byte[7:4];
                lcd_rs    <= ld_rs;
                in_ready  <= 1'b0;
                state     <= S_SETUP;
                cnt       <= L_SETUP;
                if (state == S_WAIT)
                    step <= step + 3'd1;
            end else begin
                case (state)
                    S_PWR: begin
                        if (!armed) begin
                            armed <= 1'b1;
                            cnt   <= L_PWRUP;
                        end
                    end
                    S_SETUP: begin
                        if (last) begin
                            state <= S_EHIGH;
                            lcd_e <= 1'b1;
                            cnt   <= L_EPW;
                        end
                    end
                    S_EHIGH: begin
                        if (last) begin
                            state <= S_HOLD;
                            lcd_e <= 1'b0;
                            cnt   <= L_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (last) begin
                            if (!nib_only && !low_phase) begin
                                low_phase <= 1'b1;
                                lcd_dq    <= lo_q;
                                state     <= S_SETUP;
                                cnt       <= L_SETUP;
                            end else begin
                                state <= S_WAIT;
                                cnt   <= wait_q;
                            end
                        end
                    end
                    S_WAIT: begin
                        // Reached only after the last init byte or a user byte.
                        if (last) begin
                            state     <= S_IDLE;
                            in_ready  <= 1'b1;
                            init_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/lcd_hd44780_writer.md
Name: lcd_hd44780_writer

Overview:
- Downstream stage of the POST-code decoder. Takes byte-wide display writes (command or character) over a valid/ready handshake.
- Performs the HD44780 power-on 4-bit initialisation itself.
- Drives the LCD's 4-bit data bus, RS and E with programmable cycle-count timing (defaults for 12 MHz refclk).
- The decoder instantiates it and routes lcd_dq/lcd_rs/lcd_e to the DIL pins.

Parameters:
- CNT_W, 18, width of the shared delay counter; must hold the largest T_* value.
- T_PWRUP, 180000, power-up wait before the first init nibble (15 ms).
- T_INIT1, 49200, wait after the first 0x3 init nibble (4.1 ms).
- T_INIT2, 1200, wait after the 2nd/3rd 0x3 nibble and after the 0x2 nibble (100 us).
- T_SETUP, 1, cycles RS/DQ are stable before E rises.
- T_EPW, 6, E-high width in cycles (500 ns).
- T_HOLD, 12, cycles E is low with DQ held after each nibble (1 us).
- T_EXEC, 480, post-byte execution wait (40 us).
- T_EXEC_LONG, 19680, post-byte wait for clear/home (1.64 ms).

Ports:
- refclk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  write request
- in_ready  output  1  block can accept a byte this cycle
- in_rs  input  1  0 = command, 1 = data/character
- in_data  input  8  byte to write
- init_done  output  1  init sequence complete (sticky until reset)
- lcd_dq  output  4  LCD D7..D4
- lcd_rs  output  1  LCD register select
- lcd_e  output  1  LCD enable strobe

Behaviour:
- Clocking: one clock (refclk); reset is synchronous, active-high. All outputs registered.
- Reset values:
  - in_ready=0, init_done=0, lcd_dq=0, lcd_rs=0, lcd_e=0.
  - State=PWR_WAIT, counter cleared.
  - Reset asserted mid-operation aborts everything (E drops the next cycle) and restarts the full init sequence.
- Nibble write primitive (NIB_SETUP → NIB_EHIGH → NIB_HOLD):
  - Cycle 0: lcd_rs/lcd_dq take the new value, lcd_e=0.
  - lcd_e=1 for exactly T_EPW cycles starting T_SETUP cycles later.
  - lcd_e=0 for T_HOLD cycles; lcd_dq/lcd_rs unchanged through hold.
- Byte write: high nibble (in_data[7:4]), then low nibble, then a wait state of T_EXEC cycles.
  - Use T_EXEC_LONG instead when rs=0 and data[7:2]==0 (clear 0x01, home 0x02/0x03).
  - Busy time from acceptance edge to in_ready re-high = 2*(T_SETUP+T_EPW+T_HOLD)+wait, exactly.
- Init sequence (all RS=0), strictly in order:
  1. PWR_WAIT for T_PWRUP.
  2. Nibble 0x3, wait T_INIT1.
  3. Nibble 0x3, wait T_INIT2.
  4. Nibble 0x3, wait T_INIT2.
  5. Nibble 0x2, wait T_INIT2.
  6. Bytes 0x28, 0x0C, 0x01, 0x06, each with its normal post-byte wait (0x01 uses T_EXEC_LONG).
  7. Enter IDLE, set init_done=1 and in_ready=1 on the same cycle.
- Init bytes come from a 4-entry internal ROM. Init nibble-only writes reuse the nibble primitive and skip the low nibble.
- Handshake:
  - in_ready=1 only in IDLE after init.
  - Transfer occurs on a rising edge with in_valid&in_ready; in_ready drops on the following cycle.
  - in_rs/in_data are captured at transfer; later changes are ignored.
  - in_valid before init_done is not accepted and is not lost: it stays pending until ready.
  - in_valid held high continuously gives back-to-back bytes, each separated only by the computed busy time.
- Idle: lcd_e=0; lcd_dq and lcd_rs hold the last driven values.
- Counter: a single down-counter loaded per phase with (T_x − 1), reaching zero to advance. T_x values of 1 must work (single-cycle phase). No wrap: the counter never decrements below 0.
- E never asserts outside NIB_EHIGH. No glitch on lcd_e at state transitions.

Test Plan:
- Reset/init (bench: T_PWRUP=100, T_INIT1=50, T_INIT2=20, T_SETUP=1, T_EPW=3, T_HOLD=2, T_EXEC=10, T_EXEC_LONG=40):
  - Outputs 0 during reset and for 100 cycles after.
  - Nibble sequence 3,3,3,2, then high/low pairs 2,8 / 0,C / 0,1 / 0,6, all with lcd_rs=0.
  - Gaps between E pulses match the T_* values.
  - init_done and in_ready rise together after 0x06's 10-cycle wait.
- Data write 'A' (rs=1, 0x41) after init:
  - lcd_rs=1, dq=4 then dq=1.
  - Each E pulse is exactly 3 cycles high, 1 cycle after its dq change.
  - in_ready returns exactly 2*(1+3+2)+10 = 22 cycles after the acceptance edge.
- Clear command (rs=0, 0x01): in_ready returns 2*6+40 = 52 cycles after acceptance. Command 0x04 uses the 10-cycle wait (22 total).
- Back-to-back: in_valid held high with 0x50, 0x4F, 0x53, 0x54:
  - Four bytes emitted in order, none dropped or duplicated.
  - in_data changes while busy are not sampled.
- Early request: in_valid=1 with 0x30 from reset release:
  - Not accepted until init_done.
  - Accepted on the first in_ready cycle; first user nibble is 3.
- Reset mid-operation: assert reset while lcd_e=1 during a user byte:
  - lcd_e=0 the next cycle, all outputs 0.
  - Full init sequence repeats from PWR_WAIT.
